elink_stub: RTL and testbench



---
 rtl/elink_stub_pkg.sv | 15 +
 rtl/elink_stub_chan.sv | 35 +++
 rtl/elink_stub.sv | 168 ++++++++++++++++
 tb/tb_elink_stub.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/elink_stub_pkg.sv
// Shared types and codes for the eLink loopback stub.
package elink_stub_pkg;

    typedef logic [1:0] pkt_t;

    localparam logic [1:0] CH_WR    = 2'b01;
    localparam logic [1:0] CH_RD    = 2'b10;
    localparam logic [1:0] CH_RR    = 2'b11;
    localparam pkt_t       PKT_MBOX = 2'b11;

    function automatic logic [7:0] link_word(input logic [1:0] chan, input pkt_t pkt);
        return {4'b0000, chan, pkt};
    endfunction

endpackage

// File: rtl/elink_stub_chan.sv
// One loopback channel: single-entry receive register with valid/wait handshake.
module elink_stub_chan
    import elink_stub_pkg::*;
(
    input  logic clk,
    input  logic rst_b,
    input  logic tx_access,
    input  pkt_t tx_packet,
    input  logic rwait,
    input  logic stall,
    input  logic fwd,
    output logic tx_wait,
    output logic xfer,
    output logic rx_access,
    output pkt_t rx_packet,
    input  logic rx_wait
);

    assign tx_wait = (rx_access & rx_wait) | rwait | stall;
    assign xfer    = tx_access & ~tx_wait;

    // A non-forwarded transfer (mailbox push) behaves like an idle cycle for the register.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            rx_access <= 1'b0;
            rx_packet <= '0;
        end else if (xfer && fwd) begin
            rx_access <= 1'b1;
            rx_packet <= tx_packet;
        end else if (rx_access && !rx_wait) begin
            rx_access <= 1'b0;
        end
    end

endmodule

// File: rtl/elink_stub.sv
// eLink behavioural stand-in: channel loopback, link pin patterns, optional mailbox
// (mailbox enabled by defining ELINK_STUB_MAILBOX_EN).
module elink_stub
    import elink_stub_pkg::*;
#(
    parameter logic [3:0] ROWID      = 4'h8,
    parameter logic [3:0] COLID      = 4'h8,
    parameter int         MBOX_DEPTH = 4
) (
    input  logic       clkin,
    input  logic       hard_resetb,
    input  logic       txwr_access,
    input  pkt_t       txwr_packet,
    output logic       txwr_wait,
    input  logic       txrd_access,
    input  pkt_t       txrd_packet,
    output logic       txrd_wait,
    input  logic       txrr_access,
    input  pkt_t       txrr_packet,
    output logic       txrr_wait,
    output logic       rxwr_access,
    output pkt_t       rxwr_packet,
    input  logic       rxwr_wait,
    output logic       rxrd_access,
    output pkt_t       rxrd_packet,
    input  logic       rxrd_wait,
    output logic       rxrr_access,
    output pkt_t       rxrr_packet,
    input  logic       rxrr_wait,
    input  logic       txwr_clk,
    input  logic       txrd_clk,
    input  logic       txrr_clk,
    input  logic       rxwr_clk,
    input  logic       rxrd_clk,
    input  logic       rxrr_clk,
    input  logic       txi_wr_wait_p,
    input  logic       txi_wr_wait_n,
    input  logic       txi_rd_wait_p,
    input  logic       txi_rd_wait_n,
    input  logic       rxi_lclk_p,
    input  logic       rxi_lclk_n,
    input  logic       rxi_frame_p,
    input  logic       rxi_frame_n,
    input  logic [7:0] rxi_data_p,
    input  logic [7:0] rxi_data_n,
    output logic       txo_lclk_p,
    output logic       txo_lclk_n,
    output logic       txo_frame_p,
    output logic       txo_frame_n,
    output logic [7:0] txo_data_p,
    output logic [7:0] txo_data_n,
    output logic       rxo_wr_wait_p,
    output logic       rxo_wr_wait_n,
    output logic       rxo_rd_wait_p,
    output logic       rxo_rd_wait_n,
    output logic       cclk_p,
    output logic       cclk_n,
    output logic       chip_resetb,
    output logic [3:0] rowid,
    output logic [3:0] colid,
    input  logic [2:0] clkbypass,
    output logic       mailbox_not_empty,
    output logic       mailbox_full
);

    logic rwait_wr, rwait_rd;
    logic wr_xfer, rd_xfer, rr_xfer;
    logic wr_stall, wr_fwd;
    logic frame_q, lclk_q, chip_resetb_q;
    logic [7:0] data_q;

    assign rwait_wr = txi_wr_wait_p & ~txi_wr_wait_n;
    assign rwait_rd = txi_rd_wait_p & ~txi_rd_wait_n;

`ifdef ELINK_STUB_MAILBOX_EN
    localparam logic [3:0] DEPTH = 4'(MBOX_DEPTH);
    logic [3:0] mbox_count;
    logic       push, pop;

    assign mailbox_full      = (mbox_count == DEPTH);
    assign mailbox_not_empty = (mbox_count != 4'd0);
    assign wr_stall          = txwr_access & (txwr_packet == PKT_MBOX) & mailbox_full;
    assign wr_fwd            = (txwr_packet != PKT_MBOX);
    assign push              = wr_xfer & (txwr_packet == PKT_MBOX);
    assign pop               = rd_xfer & (txrd_packet == PKT_MBOX) & mailbox_not_empty;

    always_ff @(posedge clkin) begin
        if (!hard_resetb) begin
            mbox_count <= 4'd0;
        end else if (push && !pop) begin
            mbox_count <= mbox_count + 4'd1;
        end else if (pop && !push) begin
            mbox_count <= mbox_count - 4'd1;
        end
    end
`else
    assign mailbox_full      = 1'b0;
    assign mailbox_not_empty = 1'b0;
    assign wr_stall          = 1'b0;
    assign wr_fwd            = 1'b1;
`endif

    elink_stub_chan u_wr (
        .clk(clkin), .rst_b(hard_resetb),
        .tx_access(txwr_access), .tx_packet(txwr_packet), .rwait(rwait_wr),
        .stall(wr_stall), .fwd(wr_fwd), .tx_wait(txwr_wait), .xfer(wr_xfer),
        .rx_access(rxwr_access), .rx_packet(rxwr_packet), .rx_wait(rxwr_wait)
    );

    elink_stub_chan u_rd (
        .clk(clkin), .rst_b(hard_resetb),
        .tx_access(txrd_access), .tx_packet(txrd_packet), .rwait(rwait_rd),
        .stall(1'b0), .fwd(1'b1), .tx_wait(txrd_wait), .xfer(rd_xfer),
        .rx_access(rxrd_access), .rx_packet(rxrd_packet), .rx_wait(rxrd_wait)
    );

    elink_stub_chan u_rr (
        .clk(clkin), .rst_b(hard_resetb),
        .tx_access(txrr_access), .tx_packet(txrr_packet), .rwait(rwait_rd),
        .stall(1'b0), .fwd(1'b1), .tx_wait(txrr_wait), .xfer(rr_xfer),
        .rx_access(rxrr_access), .rx_packet(rxrr_packet), .rx_wait(rxrr_wait)
    );

    // Frame word carries the highest-priority channel that transferred (wr > rd > rr).
    always_ff @(posedge clkin) begin
        if (!hard_resetb) begin
            frame_q <= 1'b0;
            data_q  <= 8'h00;
            lclk_q  <= 1'b0;
        end else begin
            lclk_q  <= ~lclk_q;
            frame_q <= wr_xfer | rd_xfer | rr_xfer;
            if (wr_xfer) begin
                data_q <= link_word(CH_WR, txwr_packet);
            end else if (rd_xfer) begin
                data_q <= link_word(CH_RD, txrd_packet);
            end else if (rr_xfer) begin
                data_q <= link_word(CH_RR, txrr_packet);
            end
        end
    end

    always_ff @(posedge clkin) begin
        chip_resetb_q <= hard_resetb;
    end

    assign txo_frame_p   = frame_q;
    assign txo_frame_n   = ~frame_q;
    assign txo_data_p    = data_q;
    assign txo_data_n    = ~data_q;
    assign txo_lclk_p    = lclk_q;
    assign txo_lclk_n    = ~lclk_q;
    assign cclk_p        = lclk_q;
    assign cclk_n        = ~lclk_q;
    assign rxo_wr_wait_p = mailbox_full;
    assign rxo_wr_wait_n = ~mailbox_full;
    assign rxo_rd_wait_p = 1'b0;
    assign rxo_rd_wait_n = 1'b1;
    assign chip_resetb   = chip_resetb_q;
    assign rowid         = ROWID;
    assign colid         = COLID;

    logic unused_inputs;
    assign unused_inputs = ^{txwr_clk, txrd_clk, txrr_clk, rxwr_clk, rxrd_clk, rxrr_clk,
                             rxi_lclk_p, rxi_lclk_n, rxi_frame_p, rxi_frame_n,
                             rxi_data_p, rxi_data_n, clkbypass};

endmodule

// File: tb/tb_elink_stub.sv
// Self-checking bench for elink_stub: directed scenarios then randomized traffic vs a reference model.
module tb_elink_stub;

`ifdef ELINK_STUB_MAILBOX_EN
    localparam bit MBOX_EN = 1'b1;
`else
    localparam bit MBOX_EN = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic clkin = 1'b0;
    always #5 clkin = ~clkin;

    logic            rstb;
    logic [2:0]      acc;
    logic [2:0][1:0] pkt;
    logic [2:0]      rxw;
    logic            wwp, wwn, rwp, rwn;
    logic [5:0]      ign_clk;
    logic [3:0]      ign_pins;
    logic [7:0]      ign_dp, ign_dn;
    logic [2:0]      ign_byp;

    logic txwr_wait, txrd_wait, txrr_wait;
    logic rxwr_access, rxrd_access, rxrr_access;
    logic [1:0] rxwr_packet, rxrd_packet, rxrr_packet;
    logic txo_lclk_p, txo_lclk_n, txo_frame_p, txo_frame_n;
    logic [7:0] txo_data_p, txo_data_n;
    logic rxo_wr_wait_p, rxo_wr_wait_n, rxo_rd_wait_p, rxo_rd_wait_n;
    logic cclk_p, cclk_n, chip_resetb, mailbox_not_empty, mailbox_full;
    logic [3:0] rowid, colid;

    elink_stub #(.MBOX_DEPTH(DEPTH)) dut (
        .clkin(clkin), .hard_resetb(rstb),
        .txwr_access(acc[0]), .txwr_packet(pkt[0]), .txwr_wait(txwr_wait),
        .txrd_access(acc[1]), .txrd_packet(pkt[1]), .txrd_wait(txrd_wait),
        .txrr_access(acc[2]), .txrr_packet(pkt[2]), .txrr_wait(txrr_wait),
        .rxwr_access(rxwr_access), .rxwr_packet(rxwr_packet), .rxwr_wait(rxw[0]),
        .rxrd_access(rxrd_access), .rxrd_packet(rxrd_packet), .rxrd_wait(rxw[1]),
        .rxrr_access(rxrr_access), .rxrr_packet(rxrr_packet), .rxrr_wait(rxw[2]),
        .txwr_clk(ign_clk[0]), .txrd_clk(ign_clk[1]), .txrr_clk(ign_clk[2]),
        .rxwr_clk(ign_clk[3]), .rxrd_clk(ign_clk[4]), .rxrr_clk(ign_clk[5]),
        .txi_wr_wait_p(wwp), .txi_wr_wait_n(wwn), .txi_rd_wait_p(rwp), .txi_rd_wait_n(rwn),
        .rxi_lclk_p(ign_pins[0]), .rxi_lclk_n(ign_pins[1]),
        .rxi_frame_p(ign_pins[2]), .rxi_frame_n(ign_pins[3]),
        .rxi_data_p(ign_dp), .rxi_data_n(ign_dn),
        .txo_lclk_p(txo_lclk_p), .txo_lclk_n(txo_lclk_n),
        .txo_frame_p(txo_frame_p), .txo_frame_n(txo_frame_n),
        .txo_data_p(txo_data_p), .txo_data_n(txo_data_n),
        .rxo_wr_wait_p(rxo_wr_wait_p), .rxo_wr_wait_n(rxo_wr_wait_n),
        .rxo_rd_wait_p(rxo_rd_wait_p), .rxo_rd_wait_n(rxo_rd_wait_n),
        .cclk_p(cclk_p), .cclk_n(cclk_n), .chip_resetb(chip_resetb),
        .rowid(rowid), .colid(colid), .clkbypass(ign_byp),
        .mailbox_not_empty(mailbox_not_empty), .mailbox_full(mailbox_full)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: what each receive slot holds, mailbox occupancy, link pin state.
    bit         m_valid [3];
    logic [1:0] m_pkt   [3];
    int         m_cnt   = 0;
    bit         m_frame = 0;
    logic [7:0] m_data  = 8'h00;
    bit         m_clk   = 0;
    bit         m_crb   = 0;

    task automatic cycle();
        bit [2:0] w, x;
        bit rw_wr, rw_rd, full, push, pop, accepted;
        #1;
        rw_wr = wwp && !wwn;
        rw_rd = rwp && !rwn;
        full  = MBOX_EN && (m_cnt == DEPTH);
        w[0]  = (m_valid[0] && rxw[0]) || rw_wr || (full && acc[0] && pkt[0] == 2'b11);
        w[1]  = (m_valid[1] && rxw[1]) || rw_rd;
        w[2]  = (m_valid[2] && rxw[2]) || rw_rd;
        check("txwr_wait", txwr_wait, w[0]);
        check("txrd_wait", txrd_wait, w[1]);
        check("txrr_wait", txrr_wait, w[2]);
        @(posedge clkin);
        m_crb = rstb;
        if (!rstb) begin
            for (int c = 0; c < 3; c++) begin m_valid[c] = 0; m_pkt[c] = 2'b00; end
            m_cnt = 0; m_frame = 0; m_data = 8'h00; m_clk = 0;
        end else begin
            x = acc & ~w;
            push = x[0] && MBOX_EN && pkt[0] == 2'b11;
            pop  = x[1] && MBOX_EN && pkt[1] == 2'b11 && m_cnt > 0;
            m_cnt = m_cnt + int'(push) - int'(pop);
            accepted = 0;
            for (int c = 0; c < 3; c++) begin
                if (x[c] && !(c == 0 && push)) begin
                    m_valid[c] = 1; m_pkt[c] = pkt[c];
                end else if (m_valid[c] && !rxw[c]) begin
                    m_valid[c] = 0;
                end
                if (x[c] && !accepted) begin
                    m_data = {4'b0000, 2'(c + 1), pkt[c]};
                    accepted = 1;
                end
            end
            m_frame = accepted;
            m_clk = !m_clk;
        end
        #1;
        check("rxwr", {rxwr_access, rxwr_packet}, {m_valid[0], m_pkt[0]});
        check("rxrd", {rxrd_access, rxrd_packet}, {m_valid[1], m_pkt[1]});
        check("rxrr", {rxrr_access, rxrr_packet}, {m_valid[2], m_pkt[2]});
        check("frame", {txo_frame_p, txo_frame_n}, {m_frame, !m_frame});
        check("data", {txo_data_p, txo_data_n}, {m_data, ~m_data});
        check("clocks", {txo_lclk_p, txo_lclk_n, cclk_p, cclk_n}, {m_clk, !m_clk, m_clk, !m_clk});
        check("chip_resetb", chip_resetb, m_crb);
        check("mbox", {mailbox_not_empty, mailbox_full, rxo_wr_wait_p, rxo_wr_wait_n},
              {MBOX_EN && m_cnt != 0, MBOX_EN && m_cnt == DEPTH,
               MBOX_EN && m_cnt == DEPTH, !(MBOX_EN && m_cnt == DEPTH)});
        check("rd_wait_pins", {rxo_rd_wait_p, rxo_rd_wait_n}, 2'b01);
    endtask

    initial begin
        for (int c = 0; c < 3; c++) begin m_valid[c] = 0; m_pkt[c] = 2'b00; end
        rstb = 0; acc = '0; pkt = '0; rxw = '0;
        wwp = 0; wwn = 0; rwp = 0; rwn = 0;
        ign_clk = '0; ign_pins = '0; ign_dp = '0; ign_dn = '0; ign_byp = '0;

        repeat (3) cycle();
        check("rst_rx_access", {rxwr_access, rxrd_access, rxrr_access}, 3'b000);
        check("rst_data_n", txo_data_n, 8'hFF);
        check("rst_chip_resetb", chip_resetb, 1'b0);
        check("ids", {rowid, colid}, 8'h88);
        rstb = 1;
        cycle();
        check("chip_resetb_rel", chip_resetb, 1'b1);
        check("cclk_first", {cclk_p, txo_lclk_p}, 2'b11);
        cycle();
        check("cclk_second", {cclk_p, cclk_n, txo_lclk_n}, 3'b011);

        acc = 3'b001; pkt[0] = 2'b01;
        cycle();
        check("loop_rxwr", {rxwr_access, rxwr_packet}, 3'b101);
        check("loop_frame", txo_frame_p, 1'b1);
        check("loop_data", txo_data_p, 8'h05);
        acc = '0;
        cycle();

        rxw[1] = 1; acc = 3'b010; pkt[1] = 2'b10;
        cycle();
        pkt[1] = 2'b01;
        #1;
        check("bp_txrd_wait", txrd_wait, 1'b1);
        cycle();
        cycle();
        check("bp_held", {rxrd_access, rxrd_packet}, 3'b110);
        rxw[1] = 0;
        cycle();
        check("bp_second", {rxrd_access, rxrd_packet}, 3'b101);
        acc = '0;
        cycle();
        check("bp_drain", rxrd_access, 1'b0);

        rwp = 1; rwn = 0; acc = 3'b111; pkt = 6'b01_10_01;
        #1;
        check("rwait_rd_rr", {txrd_wait, txrr_wait}, 2'b11);
        check("rwait_wr", txwr_wait, 1'b0);
        cycle();
        rwp = 0; acc = '0;
        cycle();

`ifdef ELINK_STUB_MAILBOX_EN
        rstb = 0;
        cycle();
        rstb = 1; acc = 3'b001; pkt[0] = 2'b11;
        repeat (4) cycle();
        check("mbox_full", mailbox_full, 1'b1);
        check("mbox_no_fwd", rxwr_access, 1'b0);
        #1;
        check("mbox_stall", txwr_wait, 1'b1);
        cycle();
        acc = 3'b010; pkt[1] = 2'b11;
        cycle();
        check("mbox_pop_full", mailbox_full, 1'b0);
        check("mbox_pop_fwd", {rxrd_access, rxrd_packet}, 3'b111);
        acc = '0;
        cycle();
`endif

        for (int i = 0; i < 1500; i++) begin
            rstb = ($urandom_range(99) != 0);
            acc  = 3'($urandom);
            pkt  = 6'($urandom);
            for (int c = 0; c < 3; c++) rxw[c] = ($urandom_range(9) < 4);
            wwp = ($urandom_range(7) == 0); wwn = 1'($urandom);
            rwp = ($urandom_range(7) == 0); rwn = 1'($urandom);
            ign_clk = 6'($urandom); ign_pins = 4'($urandom);
            ign_dp = 8'($urandom); ign_dn = 8'($urandom); ign_byp = 3'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
